load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store front end between the single-cycle core's execute stage and the word-organised data memory. Accepts byte/halfword/word load and store requests on a byte address and checks alignment and range. Converts each request into word-indexed memory accesses, with read-modify-write for sub-word stores. Returns sign- or zero-extended load data through a one-cycle response pulse.

## Interface
- ADDR_W, 8, byte-address bits backed by memory (2^(ADDR_W-2) = 64 words)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load result; holds until next load completes
- rsp_err  out  1  valid with rsp_valid; misaligned, out-of-range or illegal size
- mem_read  out  1  to data memory MemRead
- mem_write  out  1  to data memory MemWrite
- mem_addr  out  32  word index {26'd0, addr[7:2]}
- mem_wdata  out  32  to data memory Write_data
- mem_rdata  in  32  from data memory; combinational, valid in the same cycle as mem_read

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE: req_ready=1. On accept, latch addr, size, we, unsigned and wdata.
  - Error if req_size==11, req_addr[31:ADDR_W]!=0, half with addr[0]=1, or word with addr[1:0]!=0. On error go to DONE with err flag set. No memory access occurs.
  - Otherwise go to LOAD for a load, WRITE for a word store, RMW_RD for a byte or half store.
- LOAD: mem_read=1. Select the lane from mem_rdata, extend it, and register it into rsp_rdata. Go to DONE.
- RMW_RD: mem_read=1. Register mem_rdata into the merge word. Go to WRITE.
- WRITE: mem_write=1. mem_wdata is the latched wdata for a word store, or the merge word with the target lane replaced for a byte or half store. Go to DONE.
- DONE: rsp_valid=1 and rsp_err=err flag. Go to IDLE.
- Lane rules are little-endian:
  - byte k = bits [8k+7:8k], with k = addr[1:0]
  - half at addr[1] = bits [16·addr[1]+15 : 16·addr[1]]
  - byte store uses wdata[7:0]; half store uses wdata[15:0]
- mem_addr is driven from the latched addr in every state. mem_read and mem_write are 0 outside their states, and are never both 1.
- An erroring load leaves rsp_rdata unchanged.

## Timing
- Reset values: state IDLE, req_ready 1 (the cycle after reset), rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_read 0, mem_write 0, mem_wdata 0, mem_addr 0.
- Request accepted at edge E0. Response cycle counted from E0:
  - load: LOAD in cycle 1, rsp_valid in cycle 2
  - word store: write commits at end of cycle 1, rsp_valid in cycle 2
  - sub-word store: read in cycle 1, write commits at end of cycle 2, rsp_valid in cycle 3
  - error: rsp_valid with rsp_err in cycle 1
- req_ready is 0 from the cycle after accept through DONE. A new request is accepted at the earliest in the cycle after DONE.
- No response backpressure: rsp_valid is exactly one cycle.
- rst mid-operation:
  - mem_write is gated by !rst, so a WRITE-state cycle with rst=1 never commits.
  - The next state is IDLE and the in-flight response is dropped (no rsp_valid).
- Inputs other than req_valid are don't-care when not accepted. Latched fields are immune to input changes after accept.

## Test plan
- Reset, then word store addr 0x10, data 0xDEADBEEF: mem_write=1 for one cycle with mem_addr=4. Then a word load from 0x10 gives rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after accept.
- Word 4 = 0xDEADBEEF; byte store 0xA5 to 0x11: read cycle, then write with mem_wdata=0xDEADA5EF, rsp_valid 3 cycles after accept. Then:
  - LB 0x11 (signed) gives 0xFFFFFFA5
  - LBU 0x11 gives 0x000000A5
- Half store 0x8001 to 0x12 over 0xDEADA5EF writes 0x8001A5EF. Then:
  - LH 0x12 gives 0xFFFF8001
  - LHU 0x12 gives 0x00008001
- Error cases: LW 0x13, LH 0x21, req_size=11, and SW 0x100. Each gives rsp_valid one cycle after accept with rsp_err=1, mem_read and mem_write never asserted, and rsp_rdata unchanged.
- Assert rst during the WRITE cycle of a byte store: no memory write occurs, no rsp_valid follows, and state is IDLE with req_ready=1 after reset release.
- Hold req_valid=1 for back-to-back word loads at 0x0 and 0x4: the second accept occurs only after the first DONE, and req_wdata and req_addr changes while busy have no effect.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bundles the core-side request/response handshake and the data-memory port
// of the load/store unit so both sides connect through a single port.
interface load_store_unit_if;
  // Request handshake: a request transfers on a rising edge where req_valid
  // and req_ready are both 1; the request fields must be stable while
  // req_valid is 1. The response is a single-cycle rsp_valid pulse and
  // cannot be back-pressured.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store front end: byte/half/word accesses on a byte address
// mapped onto a word-organised memory, with read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_we;
  logic                r_uns;
  logic                r_err;
  logic [31:0]         r_wdata;
  logic [31:0]         r_merge;
  logic [31:0]         r_rdata;

  logic                w_accept;
  logic                w_req_err;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load_ext;
  logic [31:0]         w_merged;
  logic [31:0]         w_store_word;

  assign w_accept  = bus.req_valid && (r_state == S_IDLE);
  assign w_req_err = (bus.req_size == 2'b11)
                   || (|bus.req_addr[31:ADDR_W])
                   || ((bus.req_size == 2'b01) && bus.req_addr[0])
                   || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                  w_next = S_DONE;
          else if (!bus.req_we)           w_next = S_LOAD;
          else if (bus.req_size == 2'b10) w_next = S_WRITE;
          else                            w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_DONE;
      S_RMW_RD: w_next = S_WRITE;
      S_WRITE:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane replacement for sub-word stores (little-endian).
  always_comb begin
    w_byte = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load_ext = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_ext = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_ext = bus.mem_rdata;
    endcase
    w_merged = r_merge;
    if (r_size == 2'b00) w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else                 w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
    w_store_word = (r_size == 2'b10) ? r_wdata : w_merged;
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wdata = 32'd0;
    bus.rsp_valid = 1'b0;
    bus.rsp_err   = 1'b0;
    case (r_state)
      S_IDLE:   bus.req_ready = 1'b1;
      S_LOAD:   bus.mem_read  = 1'b1;
      S_RMW_RD: bus.mem_read  = 1'b1;
      S_WRITE: begin
        // A write cycle coinciding with reset must never commit.
        bus.mem_write = !rst;
        bus.mem_wdata = w_store_word;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= 32'd0;
      r_merge <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr  <= bus.req_addr[ADDR_W-1:0];
        r_size  <= bus.req_size;
        r_we    <= bus.req_we;
        r_uns   <= bus.req_unsigned;
        r_err   <= w_req_err;
        r_wdata <= bus.req_wdata;
      end
      if (r_state == S_LOAD)   r_rdata <= w_load_ext;
      if (r_state == S_RMW_RD) r_merge <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = {{(34 - ADDR_W){1'b0}}, r_addr[ADDR_W-1:2]};
  assign bus.rsp_rdata = r_rdata;
  assign o_dbg_state   = r_state;

  // r_we only steers the FSM at accept time; kept latched for debug visibility.
  logic w_unused;
  assign w_unused = r_we;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of requests with scoreboarded responses,
// plus hand-written back-to-back and reset-during-write sequences.
module tb_load_store_unit;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  load_store_unit_if bus ();

  load_store_unit #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory model: combinational read, write on rising edge
  logic [31:0] mem [64];
  assign bus.mem_rdata = mem[bus.mem_addr[5:0]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;    // load result (loads without error only)
    logic [31:0] wexp;     // word written to memory (stores without error only)
    int          lat;      // cycles from accept to rsp_valid
  } vec_t;

  localparam int NV = 18;
  vec_t        tbl [NV];
  logic [32:0] exp_q [$];   // {err, rdata}
  logic [31:0] last_rdata;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: pop on every response pulse
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[32]});
        check("rsp_rdata", bus.rsp_rdata, e[31:0]);
      end
    end
  end

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata,
                              input logic [31:0] wexp, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.wexp = wexp; v.lat = lat;
    return v;
  endfunction

  task automatic wait_ready(input string name);
    int tmo;
    tmo = 0;
    while (!bus.req_ready && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    if (!bus.req_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic scramble_inputs();
    bus.req_we       = 1'($urandom_range(0, 1));
    bus.req_size     = 2'($urandom_range(0, 3));
    bus.req_unsigned = 1'($urandom_range(0, 1));
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
  endtask

  // driver: one request, then observe the memory port until the response
  task automatic run_vec(input vec_t v, input int idx);
    int          lat, nrd, nwr, both, exp_rd, exp_wr;
    bit          got;
    logic [31:0] wd, ma;
    string       nm;
    nm = $sformatf("v%0d", idx);
    wait_ready(nm);
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    if (!v.we && !v.err) last_rdata = v.rdata;
    exp_q.push_back({v.err, last_rdata});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    scramble_inputs();
    lat = 0; nrd = 0; nwr = 0; both = 0; got = 0; wd = 32'd0; ma = 32'd0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.mem_read)  begin nrd++; ma = bus.mem_addr; end
      if (bus.mem_write) begin nwr++; ma = bus.mem_addr; wd = bus.mem_wdata; end
      if (bus.mem_read && bus.mem_write) both++;
      if (bus.rsp_valid) got = 1;
    end
    exp_rd = v.err ? 0 : ((!v.we || v.size != 2'b10) ? 1 : 0);
    exp_wr = (v.err || !v.we) ? 0 : 1;
    check({nm, "_latency"}, 32'(lat), 32'(v.lat));
    check({nm, "_reads"}, 32'(nrd), 32'(exp_rd));
    check({nm, "_writes"}, 32'(nwr), 32'(exp_wr));
    check({nm, "_rd_wr_overlap"}, 32'(both), 32'd0);
    if (!v.err) check({nm, "_mem_addr"}, ma, {26'd0, v.addr[7:2]});
    if (v.we && !v.err) check({nm, "_mem_wdata"}, wd, v.wexp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:1] rdy_seen, rv_seen;
    n_cmp = 0; n_fail = 0; last_rdata = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'h1122_3344;
    mem[1] = 32'h5566_7788;

    //             we    size   uns   addr          wdata          err   rdata          wexp           lat
    tbl[0]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,         32'hDEAD_BEEF, 2);
    tbl[1]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 32'h0,         2);
    tbl[2]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h1234_56A5, 1'b0, 32'h0,         32'hDEAD_A5EF, 3);
    tbl[3]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         1'b0, 32'hFFFF_FFA5, 32'h0,         2);
    tbl[4]  = mk(1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         1'b0, 32'h0000_00A5, 32'h0,         2);
    tbl[5]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'hCAFE_8001, 1'b0, 32'h0,         32'h8001_A5EF, 3);
    tbl[6]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         1'b0, 32'hFFFF_8001, 32'h0,         2);
    tbl[7]  = mk(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         1'b0, 32'h0000_8001, 32'h0,         2);
    tbl[8]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0,         32'h0,         1);
    tbl[9]  = mk(1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0,         1'b1, 32'h0,         32'h0,         1);
    tbl[10] = mk(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0,         32'h0,         1);
    tbl[11] = mk(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h1111_1111, 1'b1, 32'h0,         32'h0,         1);
    tbl[12] = mk(1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hFFFF_FFEF, 32'h0,         2);
    tbl[13] = mk(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'h0000_A5EF, 32'h0,         2);
    tbl[14] = mk(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         1'b0, 32'h0000_0080, 32'h0,         2);
    tbl[15] = mk(1'b1, 2'b00, 1'b0, 32'h0000_00FF, 32'hABCD_EF77, 1'b0, 32'h0,         32'h7700_0000, 3);
    tbl[16] = mk(1'b0, 2'b10, 1'b0, 32'h0000_00FC, 32'h0,         1'b0, 32'h7700_0000, 32'h0,         2);
    tbl[17] = mk(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0,         32'h0,         1);

    // reset
    rst = 1'b1;
    bus.req_valid = 1'b0;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata, 32'd0);
    check("reset_state", {29'd0, dbg_state}, 32'd0);

    for (int i = 0; i < NV; i++) run_vec(tbl[i], i);
    check("mem_word4", mem[4], 32'h8001_A5EF);
    check("mem_word63", mem[63], 32'h7700_0000);

    // back-to-back loads with req_valid held; inputs changed while busy
    wait_ready("b2b");
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    exp_q.push_back({1'b0, 32'h1122_3344});
    @(posedge clk);
    #1;
    bus.req_addr  = 32'h4;
    bus.req_wdata = $urandom;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rdy_seen[c] = bus.req_ready;
      rv_seen[c]  = bus.rsp_valid;
      if (c == 3) exp_q.push_back({1'b0, 32'h5566_7788});
      if (c == 4) bus.req_valid = 1'b0;
    end
    check("b2b_ready_pattern", {27'd0, rdy_seen}, {27'd0, 5'b00100});
    check("b2b_rsp_pattern", {27'd0, rv_seen}, {27'd0, 5'b10010});

    // reset during the write cycle of a byte store
    wait_ready("rstw");
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h11;
    bus.req_wdata = 32'h5A;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstw_rmw_read", {31'd0, bus.mem_read}, 32'd1);
    @(negedge clk);
    check("rstw_state_write", {29'd0, dbg_state}, 32'd3);
    rst = 1'b1;
    #1;
    check("rstw_write_gated", {31'd0, bus.mem_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstw_idle", {29'd0, dbg_state}, 32'd0);
    check("rstw_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rstw_rdata_cleared", bus.rsp_rdata, 32'd0);
    rv_seen = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rv_seen[c] = bus.rsp_valid;
    end
    check("rstw_no_rsp", {27'd0, rv_seen}, 32'd0);
    check("rstw_mem_word4", mem[4], 32'h8001_A5EF);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
